// File: rtl/ble_cfg_pkg.sv
// Shared types and frame-layout helpers for the configurable basic logic element.
// The frame is the truth table followed by out_sel, ff_init and ce_en.
package ble_cfg_pkg;

    typedef enum logic [1:0] {
        StUncfg  = 2'd0,
        StLoad   = 2'd1,
        StActive = 2'd2
    } ble_state_e;

    function automatic int unsigned cfg_w(input int unsigned k);
        return (32'd1 << k) + 32'd3;
    endfunction

    function automatic int unsigned off_out_sel(input int unsigned k);
        return 32'd1 << k;
    endfunction

    function automatic int unsigned off_ff_init(input int unsigned k);
        return (32'd1 << k) + 32'd1;
    endfunction

    function automatic int unsigned off_ce_en(input int unsigned k);
        return (32'd1 << k) + 32'd2;
    endfunction

endpackage

// File: rtl/ble_cfg_chain.sv
// Configuration shift register with a saturating load counter and load-tracking FSM.
// o_enter pulses combinationally on the cycle whose edge moves LOAD into ACTIVE.
module ble_cfg_chain
    import ble_cfg_pkg::*;
#(
    parameter int unsigned CFG_W = 19,
    parameter int unsigned CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_shift,
    input  logic             i_head,
    output logic [CFG_W-1:0] o_cfg,
    output logic             o_tail,
    output logic             o_done,
    output logic             o_enter
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ble_state_e       r_state;
    ble_state_e       w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic [CFG_W-1:0] r_cfg;
    logic [CFG_W-1:0] w_cfg_d;
    logic             r_done;
    logic             w_enter;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_cfg_d   = r_cfg;
        w_enter   = 1'b0;
        if (i_shift) begin
            w_cfg_d = {i_head, r_cfg[CFG_W-1:1]};
            if (r_state == StLoad) begin
                w_cnt_d = (r_cnt == CNT_FULL) ? r_cnt : r_cnt + CNT_ONE;
            end else begin
                // The shift that starts a load is itself the first counted bit.
                w_state_d = StLoad;
                w_cnt_d   = CNT_ONE;
            end
        end else if (r_state == StLoad) begin
            if (r_cnt == CNT_FULL) begin
                w_state_d = StActive;
                w_enter   = 1'b1;
            end else begin
                w_state_d = StUncfg;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StUncfg;
            r_cnt   <= '0;
            r_cfg   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_cfg   <= w_cfg_d;
            r_done  <= (w_state_d == StActive);
        end
    end

    assign o_cfg   = r_cfg;
    assign o_tail  = r_cfg[0];
    assign o_done  = r_done;
    assign o_enter = w_enter;

endmodule

// File: rtl/ble_k_cfg.sv
// K-input LUT basic logic element with optional output flip-flop and serial configuration.
// Output is held at 0 unless a complete frame is loaded and the element is ACTIVE.
module ble_k_cfg
    import ble_cfg_pkg::*;
#(
    parameter int unsigned K     = 4,
    parameter int unsigned FF_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [K-1:0] ble_in,
    input  logic         ce,
    input  logic         sclr,
    input  logic         ccff_shift,
    input  logic         ccff_head,
    output logic         ccff_tail,
    output logic         ble_out,
    output logic         cfg_done
);

    localparam int unsigned CFG_W       = cfg_w(K);
    localparam int unsigned CNT_W       = $clog2(CFG_W + 1);
    localparam int unsigned LUT_N       = 32'd1 << K;
    localparam int unsigned OFF_OUT_SEL = off_out_sel(K);
    localparam int unsigned OFF_FF_INIT = off_ff_init(K);
    localparam int unsigned OFF_CE_EN   = off_ce_en(K);

    logic [CFG_W-1:0] w_cfg;
    logic [LUT_N-1:0] w_truth;
    logic             w_done;
    logic             w_enter;
    logic             w_lut;
    logic             w_ff;
    logic             w_reg_sel;
    logic             w_ff_init;
    logic             w_ce_en;

    ble_cfg_chain #(
        .CFG_W (CFG_W),
        .CNT_W (CNT_W)
    ) u_chain (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_shift (ccff_shift),
        .i_head  (ccff_head),
        .o_cfg   (w_cfg),
        .o_tail  (ccff_tail),
        .o_done  (cfg_done),
        .o_enter (w_enter)
    );

    assign w_done    = cfg_done;
    assign w_truth   = w_cfg[LUT_N-1:0];
    assign w_lut     = w_truth[ble_in];
    assign w_ff_init = w_cfg[OFF_FF_INIT];
    assign w_ce_en   = w_cfg[OFF_CE_EN];

    if (FF_EN != 0) begin : g_ff
        logic r_ff;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_ff <= 1'b0;
            end else if (w_enter) begin
                r_ff <= w_ff_init;
            end else if (w_done) begin
                if (sclr) begin
                    r_ff <= w_ff_init;
                end else if (!w_ce_en || ce) begin
                    r_ff <= w_lut;
                end
            end
        end

        assign w_ff      = r_ff;
        assign w_reg_sel = w_cfg[OFF_OUT_SEL];
    end else begin : g_no_ff
        assign w_ff      = 1'b0;
        assign w_reg_sel = 1'b0;
    end

    assign ble_out = w_done ? (w_reg_sel ? w_ff : w_lut) : 1'b0;

endmodule

// File: tb/tb_ble_k_cfg.sv
// Randomised bench for ble_k_cfg (K=4) against a bit-history reference model,
// plus directed literal expectations for the main scenarios.
module tb_ble_k_cfg;

    localparam int CW      = 19;
    localparam int OUT_SEL = 16;
    localparam int FF_INIT = 17;
    localparam int CE_EN   = 18;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] ble_in = 4'h0;
    logic       ce = 1'b0;
    logic       sclr = 1'b0;
    logic       ccff_shift = 1'b0;
    logic       ccff_head = 1'b0;
    logic       ccff_tail;
    logic       ble_out;
    logic       cfg_done;

    always #5 clk = ~clk;

    ble_k_cfg #(
        .K     (4),
        .FF_EN (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ble_in     (ble_in),
        .ce         (ce),
        .sclr       (sclr),
        .ccff_shift (ccff_shift),
        .ccff_head  (ccff_head),
        .ccff_tail  (ccff_tail),
        .ble_out    (ble_out),
        .cfg_done   (cfg_done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: config is simply the last CW bits ever shifted in.
    bit hist[$];
    int m_n    = 0;
    int m_mode = 0;  // 0 unconfigured, 1 loading, 2 active
    bit m_ff   = 1'b0;

    function automatic bit m_cfg(input int i);
        int idx;
        idx = hist.size() - CW + i;
        if (idx < 0) return 1'b0;
        return hist[idx];
    endfunction

    function automatic bit exp_out();
        if (m_mode != 2) return 1'b0;
        if (m_cfg(OUT_SEL)) return m_ff;
        return m_cfg(int'(ble_in));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            m_n    = 0;
            m_mode = 0;
            m_ff   = 1'b0;
        end else if (ccff_shift) begin
            if (m_mode != 1) begin
                m_mode = 1;
                m_n    = 1;
            end else begin
                m_n++;
            end
            hist.push_back(ccff_head);
            if (hist.size() > 64) void'(hist.pop_front());
        end else if (m_mode == 1) begin
            if (m_n >= CW) begin
                m_mode = 2;
                m_ff   = m_cfg(FF_INIT);
            end else begin
                m_mode = 0;
            end
        end else if (m_mode == 2) begin
            if (sclr) m_ff = m_cfg(FF_INIT);
            else if (!m_cfg(CE_EN) || ce) m_ff = m_cfg(int'(ble_in));
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cfg_done", cfg_done, m_mode == 2);
            check("ccff_tail", ccff_tail, m_cfg(0));
            check("ble_out", ble_out, exp_out());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [63:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ccff_shift = 1'b1;
            ccff_head  = bits[i];
            cyc();
        end
        ccff_shift = 1'b0;
        ccff_head  = 1'b0;
        cyc();
    endtask

    function automatic logic [18:0] mk(input logic [15:0] t, input logic os, input logic fi,
                                       input logic cen);
        return {cen, fi, os, t};
    endfunction

    logic [18:0] f_frame;
    logic [18:0] g_frame;
    logic [63:0] bits;

    initial begin
        // 1. reset
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        chk_en = 1'b1;
        check("rst_out", ble_out, 1'b0);
        check("rst_done", cfg_done, 1'b0);
        check("rst_tail", ccff_tail, 1'b0);
        for (int i = 0; i < 4; i++) begin
            ble_in = 4'($urandom);
            #1;
            check("rst_in_toggle", ble_out, 1'b0);
        end
        ble_in = 4'h0;

        // 2. combinational AND
        shift_bits(64'(mk(16'h8000, 1'b0, 1'b0, 1'b0)), CW);
        check("and_done", cfg_done, 1'b1);
        ble_in = 4'hF;
        #1 check("and_f", ble_out, 1'b1);
        ble_in = 4'h7;
        #1 check("and_7", ble_out, 1'b0);

        // 3. registered XOR
        ble_in = 4'h0;
        shift_bits(64'(mk(16'h6996, 1'b1, 1'b1, 1'b0)), CW);
        check("xor_init", ble_out, 1'b1);
        ble_in = 4'h3;
        #1 check("xor_latency", ble_out, 1'b1);
        cyc();
        check("xor_3", ble_out, 1'b0);
        ble_in = 4'h1;
        cyc();
        check("xor_1", ble_out, 1'b1);

        // 4. enable / clear
        shift_bits(64'(mk(16'h6996, 1'b1, 1'b1, 1'b1)), CW);
        check("ce_init", ble_out, 1'b1);
        ce = 1'b1;
        ble_in = 4'h3;
        cyc();
        check("ce_load", ble_out, 1'b0);
        ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ble_in = 4'($urandom);
            cyc();
            check("ce_hold", ble_out, 1'b0);
        end
        sclr = 1'b1;
        cyc();
        check("sclr_noce", ble_out, 1'b1);
        sclr = 1'b0;
        ce = 1'b1;
        ble_in = 4'h3;
        cyc();
        check("ce_load2", ble_out, 1'b0);
        sclr = 1'b1;
        cyc();
        check("sclr_wins", ble_out, 1'b1);
        sclr = 1'b0;
        ce = 1'b0;

        // 5. short frame, chaining, over-long frame
        shift_bits({$urandom, $urandom}, 10);
        check("short_done", cfg_done, 1'b0);
        check("short_out", ble_out, 1'b0);
        f_frame = 19'($urandom);
        for (int i = 0; i < CW; i++) begin
            ccff_shift = 1'b1;
            ccff_head  = f_frame[i];
            cyc();
        end
        for (int i = 0; i < CW; i++) begin
            ccff_shift = 1'b1;
            ccff_head  = 1'($urandom);
            check("chain_tail", ccff_tail, f_frame[i]);
            cyc();
        end
        ccff_shift = 1'b0;
        cyc();
        g_frame = mk(16'($urandom), 1'b0, 1'b0, 1'b0);
        bits = {39'd0, g_frame, 6'($urandom)};
        shift_bits(bits, 25);
        check("long_done", cfg_done, 1'b1);
        for (int i = 0; i < 4; i++) begin
            ble_in = 4'($urandom);
            #1 check("long_lut", ble_out, g_frame[ble_in]);
        end

        // 6. async reset mid-load and while active
        for (int i = 0; i < 7; i++) begin
            ccff_shift = 1'b1;
            ccff_head  = 1'b1;
            cyc();
        end
        #1 rst_n = 1'b0;
        #1;
        check("arst_load_tail", ccff_tail, 1'b0);
        check("arst_load_done", cfg_done, 1'b0);
        check("arst_load_out", ble_out, 1'b0);
        ccff_shift = 1'b0;
        ccff_head  = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        shift_bits(64'(mk(16'h6997, 1'b1, 1'b1, 1'b0)), CW);
        check("arst_act_out", ble_out, 1'b1);
        check("arst_act_tail", ccff_tail, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_act_out0", ble_out, 1'b0);
        check("arst_act_done0", cfg_done, 1'b0);
        check("arst_act_tail0", ccff_tail, 1'b0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // random loads and user traffic, checked every cycle by the model
        for (int r = 0; r < 40; r++) begin
            shift_bits({$urandom, $urandom}, $urandom_range(5, 30));
            for (int c = 0; c < $urandom_range(3, 12); c++) begin
                ble_in = 4'($urandom);
                ce     = 1'($urandom);
                sclr   = ($urandom_range(0, 3) == 0);
                cyc();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
